// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: recovers pixel coordinates, measures line/frame lengths and reports lock.
// Define VGA_SYNC_DEC_ERRCNT_EN to build the saturating violation counter on err_count.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       sync_error,
  output logic [7:0] err_count
);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q;
  logic [3:0]  gcnt_q;
  logic        hs_seen_q;
  logic        hs_q, hs_q2, vs_q, vs_q2, blank_q, blank_q2;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic        sync_error_q;

  logic        hs_fall, vs_fall, blank_fall;
  logic [10:0] hlen;
  logic        hs_missing, line_bad, frame_ok, err_d;

  assign hs_fall    = hs_q2 & ~hs_q;
  assign vs_fall    = vs_q2 & ~vs_q;
  assign blank_fall = blank_q2 & ~blank_q;
  assign hlen       = {1'b0, hcnt_q} + 11'd1;
  assign frame_ok   = (vcnt_q == 10'(V_TOTAL));
  assign hs_missing = (state_q != SEARCH) && (hcnt_q == CNT_MAX);
  // The first hs edge after realignment closes a partial line, so MEASURE skips it.
  assign line_bad   = hs_fall && (hlen != 11'(H_TOTAL)) &&
                      ((state_q == LOCKED) || ((state_q == MEASURE) && hs_seen_q));
  assign err_d      = hs_missing | line_bad | (vs_fall && !frame_ok && (state_q != SEARCH));

  always_comb begin
    hcnt_d     = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
    line_len_d = line_len_q;
    if (hs_fall) begin
      hcnt_d     = '0;
      line_len_d = hlen[10] ? CNT_MAX : hlen[9:0];
    end
    vcnt_d        = vcnt_q;
    frame_lines_d = frame_lines_q;
    if (vs_fall) begin
      vcnt_d        = '0;
      frame_lines_d = vcnt_q;
    end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
    pix_x_d = '0;
    if (blank_q && blank_q2)
      pix_x_d = (pix_x_q == CNT_MAX) ? pix_x_q : pix_x_q + 10'd1;
    pix_y_d = pix_y_q;
    if (vs_fall)
      pix_y_d = '0;
    else if (blank_fall && (pix_y_q != CNT_MAX))
      pix_y_d = pix_y_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      gcnt_q    <= '0;
      hs_seen_q <= 1'b0;
    end else if (hs_missing || line_bad) begin
      state_q <= SEARCH;
    end else begin
      case (state_q)
        SEARCH: if (vs_fall) begin
          state_q   <= MEASURE;
          gcnt_q    <= '0;
          hs_seen_q <= 1'b0;
        end
        MEASURE: begin
          if (hs_fall) hs_seen_q <= 1'b1;
          if (vs_fall) begin
            if (frame_ok) begin
              gcnt_q <= gcnt_q + 4'd1;
              if (gcnt_q + 4'd1 == 4'(LOCK_FRAMES)) state_q <= LOCKED;
            end else begin
              gcnt_q <= '0;
            end
          end
        end
        LOCKED: if (vs_fall && !frame_ok) begin
          state_q <= MEASURE;
          gcnt_q  <= '0;
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q          <= 1'b0;
      hs_q2         <= 1'b0;
      vs_q          <= 1'b0;
      vs_q2         <= 1'b0;
      blank_q       <= 1'b0;
      blank_q2      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      sync_error_q  <= 1'b0;
    end else begin
      hs_q          <= vga_hs;
      hs_q2         <= hs_q;
      vs_q          <= vga_vs;
      vs_q2         <= vs_q;
      blank_q       <= vga_blank_n;
      blank_q2      <= blank_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      sync_error_q  <= err_d;
    end
  end

`ifdef VGA_SYNC_DEC_ERRCNT_EN
  logic [7:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_count_q <= '0;
    else if (err_d && (err_count_q != 8'hFF))
      err_count_q <= err_count_q + 8'd1;
  end
  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign locked      = (state_q == LOCKED);
  assign pix_valid   = blank_q2 & locked;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign sync_error  = sync_error_q;
endmodule
